// File: rtl/pwm_capture.sv
// PWM measurement: synchronises pwm_in and reports the high time and rise-to-rise
// period of each complete cycle in clk cycles, with a one-cycle valid strobe.
module pwm_capture #(
   parameter int WIDTH = 8,
   parameter int SYNC  = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             pwm_in,
   output logic             level,
   output logic [WIDTH-1:0] high_len,
   output logic [WIDTH-1:0] period_len,
   output logic             valid,
   output logic             stuck
);

   localparam logic [WIDTH-1:0] MAX = '1;
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   typedef enum logic [1:0] {ARM, HIGH, LOW} state_t;

   state_t           state;
   logic [SYNC-1:0]  sync_q;
   logic             prev;
   logic             pwm_s;
   logic             rise;
   logic             fall;
   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] hcap;

   // Flops reset high so an input already high at reset never looks like a rise.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q <= '1;
         prev   <= 1'b1;
      end else begin
         sync_q <= {sync_q[SYNC-2:0], pwm_in};
         prev   <= sync_q[SYNC-1];
      end
   end

   assign pwm_s = sync_q[SYNC-1];
   assign level = pwm_s;
   assign rise  = pwm_s & ~prev;
   assign fall  = ~pwm_s & prev;

   // A rise at cnt == MAX in LOW still reports, since it is checked before the timeout.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ARM;
         cnt        <= '0;
         hcap       <= '0;
         high_len   <= '0;
         period_len <= '0;
         valid      <= 1'b0;
         stuck      <= 1'b0;
      end else if (!en) begin
         state <= ARM;
         cnt   <= '0;
         valid <= 1'b0;
         stuck <= 1'b0;
      end else begin
         valid <= 1'b0;
         if (state != ARM && !rise && cnt != MAX) begin
            cnt <= cnt + ONE;
         end
         case (state)
            ARM: begin
               if (rise) begin
                  state <= HIGH;
                  cnt   <= ONE;
                  stuck <= 1'b0;
               end
            end
            HIGH: begin
               if (fall) begin
                  hcap  <= cnt;
                  state <= LOW;
               end else if (cnt == MAX) begin
                  stuck <= 1'b1;
                  state <= ARM;
               end
            end
            LOW: begin
               if (rise) begin
                  high_len   <= hcap;
                  period_len <= cnt;
                  valid      <= 1'b1;
                  cnt        <= ONE;
                  state      <= HIGH;
               end else if (cnt == MAX) begin
                  stuck <= 1'b1;
                  state <= ARM;
               end
            end
            default: state <= ARM;
         endcase
      end
   end

endmodule

// File: tb/tb_pwm_capture.sv
// Randomised and directed bench for pwm_capture, compared every cycle against
// an elapsed-time model of the measurement rules.
module tb_pwm_capture;

   localparam int WIDTH = 8;
   localparam int SYNC  = 2;
   localparam int MAX   = (1 << WIDTH) - 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             en;
   logic             pwm_in;
   logic             level;
   logic [WIDTH-1:0] high_len;
   logic [WIDTH-1:0] period_len;
   logic             valid;
   logic             stuck;

   int checks = 0;
   int errors = 0;

   // Model: sampled-input history plus times of the last rise, no FSM encoding.
   logic hist[$];
   int   t = 0;
   int   phase = 0;
   int   riseEdge = 0;
   int   hcapM = 0;
   int   mHigh = 0;
   int   mPeriod = 0;
   int   mValid = 0;
   int   mStuck = 0;

   pwm_capture #(.WIDTH(WIDTH), .SYNC(SYNC)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .pwm_in    (pwm_in),
      .level     (level),
      .high_len  (high_len),
      .period_len(period_len),
      .valid     (valid),
      .stuck     (stuck)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s at edge %0d: got %0d expected %0d", tag, t, observed, expected);
      end
   endtask

   task automatic resetHistory();
      hist = {};
      repeat (SYNC + 1) hist.push_back(1'b1);
   endtask

   // phase 0: waiting for an arming rise, 1: input high, 2: input low
   task automatic modelEdge();
      logic curS, curP, isRise, isFall;
      int   e;
      t++;
      if (!rst_n) begin
         resetHistory();
         phase = 0; mValid = 0; mStuck = 0; mHigh = 0; mPeriod = 0;
         return;
      end
      curS   = hist[1];
      curP   = hist[0];
      isRise = curS & ~curP;
      isFall = ~curS & curP;
      hist.push_back(pwm_in);
      void'(hist.pop_front());
      mValid = 0;
      if (!en) begin
         phase = 0; mStuck = 0;
         return;
      end
      e = t - riseEdge;
      if (e > MAX) e = MAX;
      if (phase == 0) begin
         if (isRise) begin
            phase = 1; riseEdge = t; mStuck = 0;
         end
      end else if (phase == 1) begin
         if (isFall) begin
            hcapM = e; phase = 2;
         end else if (e >= MAX) begin
            mStuck = 1; phase = 0;
         end
      end else begin
         if (isRise) begin
            mHigh = hcapM; mPeriod = e; mValid = 1; riseEdge = t; phase = 1;
         end else if (e >= MAX) begin
            mStuck = 1; phase = 0;
         end
      end
   endtask

   task automatic stepCycle(input logic v);
      pwm_in = v;
      @(posedge clk);
      modelEdge();
      #1;
      checkOutput("level", 32'(level), 32'(hist[1]));
      checkOutput("valid", 32'(valid), 32'(mValid));
      checkOutput("stuck", 32'(stuck), 32'(mStuck));
      checkOutput("high_len", 32'(high_len), 32'(mHigh));
      checkOutput("period_len", 32'(period_len), 32'(mPeriod));
   endtask

   task automatic applyStimulus(input int h, input int l, input int n);
      repeat (n) begin
         repeat (h) stepCycle(1'b1);
         repeat (l) stepCycle(1'b0);
      end
   endtask

   initial begin
      int h, l, sel;
      resetHistory();
      rst_n = 1'b0;
      en = 1'b1;
      pwm_in = 1'b1;

      // reset with the input held high, then release: no false rise
      repeat (4) stepCycle(1'b1);
      rst_n = 1'b1;
      repeat (5) stepCycle(1'b1);
      checkOutput("resetIdleValid", 32'(valid), 32'd0);

      applyStimulus(3, 5, 6);
      checkOutput("periodic_period", 32'(period_len), 32'd8);
      applyStimulus(1, 1, 8);
      checkOutput("minimum_high", 32'(high_len), 32'd1);
      applyStimulus(100, 155, 3);
      checkOutput("boundary_period", 32'(period_len), 32'(MAX));

      // long low: times out and raises stuck
      repeat (300) stepCycle(1'b0);
      checkOutput("stuckHeld", 32'(stuck), 32'd1);
      applyStimulus(3, 5, 4);
      checkOutput("stuckCleared", 32'(stuck), 32'd0);

      // enable drop mid-high
      stepCycle(1'b1);
      stepCycle(1'b1);
      en = 1'b0;
      stepCycle(1'b1);
      repeat (5) stepCycle(1'b0);
      repeat (3) stepCycle(1'b1);
      repeat (4) stepCycle(1'b0);
      en = 1'b1;
      applyStimulus(3, 5, 4);

      // reset pulse while in the low phase
      applyStimulus(4, 6, 3);
      repeat (4) stepCycle(1'b1);
      repeat (2) stepCycle(1'b0);
      rst_n = 1'b0;
      stepCycle(1'b0);
      rst_n = 1'b1;
      repeat (3) stepCycle(1'b0);
      applyStimulus(4, 6, 4);
      checkOutput("afterReset_high", 32'(high_len), 32'd4);

      // randomised waveforms with occasional timeouts, enable drops and resets
      for (int i = 0; i < 80; i++) begin
         sel = $urandom_range(0, 19);
         h = $urandom_range(1, 30);
         l = $urandom_range(1, 30);
         if (sel == 0) h = $urandom_range(200, 270);
         if (sel == 1) l = $urandom_range(200, 270);
         if (sel == 2) begin
            en = 1'b0;
            repeat ($urandom_range(1, 6)) stepCycle(1'($urandom_range(0, 1)));
            en = 1'b1;
         end
         if (sel == 3) begin
            rst_n = 1'b0;
            stepCycle(1'($urandom_range(0, 1)));
            rst_n = 1'b1;
         end
         applyStimulus(h, l, $urandom_range(1, 3));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
